bg_msm_rd_ctrl: RTL and testbench
=================================

# bg_msm_rd_ctrl

Read sequencer for the bank group. It sits directly upstream of the bank group's registered output mux. On a start command it walks bank addresses and drives the 32-bit bank chip-enable pattern:
- NTT mode: all 32 banks every beat.
- MSM mode: a rotating one-hot-per-quarter pattern, so four points leave per beat.

It also produces a valid strobe aligned with the output mux's registered data, honours a downstream issue permit, and reports busy/done.

## Interface
Parameters:
- ADDR_W, 10, bank address width
- RAM_LAT, 1, bank read latency in cycles (1..4); output mux adds one more register
- LEN_W, 14, width of beat-count input (≥ ADDR_W+3)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- flag_msm  in  1  0 = NTT pattern, 1 = MSM pattern; latched on accepted start
- len  in  LEN_W  number of read beats; latched on accepted start
- issue_rdy  in  1  downstream permit; a beat is issued only in a cycle where this is 1
- rd_en  out  1  bank read strobe
- rd_addr  out  ADDR_W  bank address
- ce_out  out  32  chip-enable pattern to banks and output mux
- flag_msm_o  out  1  latched mode, held stable from start to done
- dout_vld  out  1  output-mux data valid
- busy  out  1  high from accepted start through the done cycle
- done  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: wait for start.
  - RUN: issue beats.
  - DRAIN: wait for in-flight beats.
  - DONE: one cycle.
- Transitions:
  - IDLE→RUN on start when len≠0.
  - IDLE→DONE on start when len=0; no beats are issued.
  - RUN→DRAIN in the cycle the last beat issues.
  - DRAIN→DONE when the valid pipeline is empty.
  - DONE→IDLE unconditionally.
- Issue rule: in RUN with issue_rdy=1, assert rd_en and increment the beat counter.
- NTT mode:
  - ce_out = 32'hFFFF_FFFF.
  - rd_addr = beat index (mod 2^ADDR_W).
- MSM mode:
  - group g = beat[2:0]; rd_addr = beat[ADDR_W+2:3], i.e. group is the inner loop.
  - ce_out has exactly bits g, g+8, g+16, g+24 set. This is the pattern the output mux decodes.
- When rd_en=0, ce_out=0 and rd_addr holds its last value.
- start while busy is ignored; len and flag_msm are not re-latched.
- Address wrap: beats beyond the address space wrap modulo 2^ADDR_W with no error.
- rst_n low at any time, including mid-RUN or DRAIN:
  - state returns to IDLE and the beat counter and valid pipeline clear.
  - in-flight beats are discarded; no dout_vld and no done is produced for them.

## Timing
- Reset values: rd_en=0, rd_addr=0, ce_out=0, flag_msm_o=0, dout_vld=0, busy=0, done=0, state IDLE.
- rd_en, rd_addr, ce_out, done, busy and dout_vld are all registered outputs.
- start accepted at edge T: busy=1 and the first rd_en are possible from cycle T+1.
- dout_vld asserts RAM_LAT+1 cycles after the corresponding rd_en.
- The valid delay line is exactly RAM_LAT+1 stages; issue_rdy does not stall it.
- done asserts the cycle after the last dout_vld. busy deasserts the cycle after done.
- len=0: done asserts at T+1 and busy covers only that cycle.
- Sustained throughput: one beat per cycle while issue_rdy=1.

## Configuration
- BG_RD_CTRL_PERF_EN defined:
  - adds output stall_cnt[15:0], counting RUN cycles with issue_rdy=0.
  - the counter saturates at 16'hFFFF, clears on accepted start, and holds after done.
- Not defined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package bg_pkg holds:
  - BG_NUM_BANKS=32, BG_NUM_GROUPS=8, BG_GROUP_STRIDE=8.
  - the state enum {S_IDLE,S_RUN,S_DRAIN,S_DONE}.
  - function msm_ce(g) returning the 32-bit pattern.
- One sub-module, bg_vld_pipe: a parameterised RAM_LAT+1-stage valid shift register with async clear. It also reports an empty flag for the DRAIN exit.

## Test plan
- NTT, len=4, issue_rdy=1, RAM_LAT=1:
  - rd_en for 4 cycles with addr 0..3 and ce_out=FFFF_FFFF.
  - dout_vld for 4 cycles, 2 cycles later.
  - done one cycle after the last dout_vld.
- MSM, len=10:
  - ce_out sequence 0101_0101, 0202_0202, … 8080_8080, then 0101_0101, 0202_0202.
  - rd_addr 0×8, then 1×2.
- MSM, len=6, issue_rdy toggling 1,0,1,0…:
  - exactly 6 rd_en beats in 11 cycles, patterns unchanged in order.
  - stall_cnt=5 when PERF_EN is defined.
- start with len=0: no rd_en, done at T+1, busy high for one cycle; a second start during that cycle is ignored.
- rst_n pulsed low during DRAIN with 2 beats in flight: all outputs return to reset values immediately; no dout_vld and no done follow.
- ADDR_W=3, NTT, len=10: rd_addr 0..7,0,1 (wrap); 10 dout_vld pulses.

Source files
------------

// File: rtl/bg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bg_pkg
//  Description : Shared bank-group constants, read-sequencer state encoding
//                and the MSM chip-enable pattern helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bg_pkg;

    localparam int BG_NUM_BANKS    = 32;
    localparam int BG_NUM_GROUPS   = 8;
    localparam int BG_GROUP_STRIDE = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } bg_state_e;

    // One bank per quarter: bits g, g+8, g+16, g+24. The output mux decodes
    // exactly this pattern to pick four points per beat.
    function automatic logic [BG_NUM_BANKS-1:0] msm_ce(
        input logic [$clog2(BG_NUM_GROUPS)-1:0] g
    );
        logic [BG_GROUP_STRIDE-1:0] onehot;
        onehot = BG_GROUP_STRIDE'(1) << g;
        return {(BG_NUM_BANKS/BG_GROUP_STRIDE){onehot}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bg_vld_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bg_vld_pipe
//  Description : STAGES-deep valid delay line with asynchronous clear. Tracks
//                read beats through bank latency plus the output mux register.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk     in   clock, rising edge
//    rst_n   in   asynchronous active-low clear
//    i_vld   in   beat entering the line (bank read strobe)
//    o_vld   out  beat leaving the line (aligned with mux data)
//    o_empty out  no beat remains behind the output stage
// ============================================================================
module bg_vld_pipe #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vld,
    output logic o_vld,
    output logic o_empty
);

    logic [STAGES-1:0] r_stage_q;
    logic [STAGES-1:0] w_stage_d;

    always_comb begin
        w_stage_d = {r_stage_q[STAGES-2:0], i_vld};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_q <= '0;
        end else begin
            r_stage_q <= w_stage_d;
        end
    end

    assign o_vld = r_stage_q[STAGES-1];

    // The output stage itself is excluded: when only it is set, the line is
    // empty after this edge, so the done pulse lands the cycle after the
    // final valid.
    assign o_empty = ~(i_vld | (|r_stage_q[STAGES-2:0]));

endmodule
`default_nettype wire

// File: rtl/bg_msm_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bg_msm_rd_ctrl
//  Description : Bank-group read sequencer. Walks bank addresses on a start
//                command and drives the 32-bit chip-enable pattern (all banks
//                for NTT, rotating one-per-quarter for MSM), a valid strobe
//                aligned with the registered output mux, and busy/done.
//  Revision    : 1.0 - initial release
//
//  Optional feature macro: BG_RD_CTRL_PERF_EN (adds stall_cnt output)
//
//  Ports
//    clk         in   clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    start       in   command pulse, sampled only when idle
//    flag_msm    in   0 = NTT pattern, 1 = MSM pattern (latched on start)
//    len         in   number of read beats (latched on start)
//    issue_rdy   in   downstream permit for issuing a beat
//    rd_en       out  bank read strobe
//    rd_addr     out  bank address
//    ce_out      out  chip-enable pattern
//    flag_msm_o  out  latched mode
//    dout_vld    out  output-mux data valid
//    busy        out  command in progress (start through done)
//    done        out  one-cycle completion pulse
//    stall_cnt   out  RUN cycles without permit (BG_RD_CTRL_PERF_EN only)
// ============================================================================
module bg_msm_rd_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int RAM_LAT = 1,
    parameter int LEN_W   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flag_msm,
    input  logic [LEN_W-1:0]  len,
    input  logic              issue_rdy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       ce_out,
    output logic              flag_msm_o,
    output logic              dout_vld,
    output logic              busy,
    output logic              done
`ifdef BG_RD_CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    import bg_pkg::*;

    bg_state_e         r_state_q, w_state_d;
    logic [LEN_W-1:0]  r_beat_q,  w_beat_d;
    logic [LEN_W-1:0]  r_len_q,   w_len_d;
    logic              r_msm_q,   w_msm_d;
    logic              r_rd_en_q, w_rd_en_d;
    logic [ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic [31:0]       r_ce_q,    w_ce_d;
    logic              r_busy_q,  w_busy_d;
    logic              r_done_q,  w_done_d;

    logic              w_accept;
    logic              w_issue;
    logic              w_msm_eff;
    logic [LEN_W-1:0]  w_len_eff;
    logic [LEN_W-1:0]  w_beat_cur;
    logic [LEN_W-1:0]  w_beat_nxt;
    logic              w_pipe_empty;

    // A start accepted this edge may already issue beat 0, so the first
    // rd_en appears in the cycle right after acceptance. During that edge
    // the live inputs stand in for the not-yet-latched copies.
    assign w_accept   = (r_state_q == S_IDLE) && start;
    assign w_len_eff  = w_accept ? len      : r_len_q;
    assign w_msm_eff  = w_accept ? flag_msm : r_msm_q;
    assign w_beat_cur = w_accept ? '0       : r_beat_q;
    assign w_beat_nxt = w_beat_cur + LEN_W'(1);
    assign w_issue    = issue_rdy &&
                        ((w_accept && (len != '0)) || (r_state_q == S_RUN));

    always_comb begin
        w_state_d = r_state_q;
        w_beat_d  = r_beat_q;
        w_len_d   = r_len_q;
        w_msm_d   = r_msm_q;
        w_rd_en_d = 1'b0;
        w_addr_d  = r_addr_q;
        w_ce_d    = '0;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_len_d  = len;
                    w_msm_d  = flag_msm;
                    w_beat_d = '0;
                    w_busy_d = 1'b1;
                    if (len == '0) begin
                        w_state_d = S_DONE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Leaves on the last issued beat, handled below.
            end
            S_DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_d = S_DONE;
                    w_done_d  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (w_issue) begin
            w_rd_en_d = 1'b1;
            w_beat_d  = w_beat_nxt;
            if (w_msm_eff) begin
                // Group is the inner loop: eight beats share one address.
                w_addr_d = w_beat_cur[ADDR_W+2:3];
                w_ce_d   = msm_ce(w_beat_cur[2:0]);
            end else begin
                w_addr_d = w_beat_cur[ADDR_W-1:0];
                w_ce_d   = '1;
            end
            if (w_beat_nxt == w_len_eff) begin
                w_state_d = S_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_beat_q  <= '0;
            r_len_q   <= '0;
            r_msm_q   <= 1'b0;
            r_rd_en_q <= 1'b0;
            r_addr_q  <= '0;
            r_ce_q    <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_beat_q  <= w_beat_d;
            r_len_q   <= w_len_d;
            r_msm_q   <= w_msm_d;
            r_rd_en_q <= w_rd_en_d;
            r_addr_q  <= w_addr_d;
            r_ce_q    <= w_ce_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    // Bank latency plus the output mux register.
    bg_vld_pipe #(
        .STAGES (RAM_LAT + 1)
    ) u_vld_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (r_rd_en_q),
        .o_vld   (dout_vld),
        .o_empty (w_pipe_empty)
    );

`ifdef BG_RD_CTRL_PERF_EN
    logic [15:0] r_stall_q, w_stall_d;

    always_comb begin
        w_stall_d = r_stall_q;
        if (w_accept) begin
            w_stall_d = '0;
        end else if ((r_state_q == S_RUN) && !issue_rdy && (r_stall_q != 16'hFFFF)) begin
            w_stall_d = r_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_q <= '0;
        end else begin
            r_stall_q <= w_stall_d;
        end
    end

    assign stall_cnt = r_stall_q;
`endif

    assign rd_en      = r_rd_en_q;
    assign rd_addr    = r_addr_q;
    assign ce_out     = r_ce_q;
    assign flag_msm_o = r_msm_q;
    assign busy       = r_busy_q;
    assign done       = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_msm_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bg_msm_rd_ctrl
//  Description : Self-checking bench for bg_msm_rd_ctrl. Two instances: the
//                default geometry (ADDR_W=10, RAM_LAT=1) and a narrow one
//                (ADDR_W=3, RAM_LAT=3) for address wrap and deeper latency.
//                Expected outputs come from a beat schedule derived from the
//                issue_rdy pattern and the address/pattern rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_msm_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flag_msm;
    logic [13:0] len;
    logic        issue_rdy;
    logic        dut_sel;

    logic        start_m, start_n;
    assign start_m = start & ~dut_sel;
    assign start_n = start &  dut_sel;

    logic        m_rd_en, m_flag, m_vld, m_busy, m_done;
    logic [9:0]  m_addr;
    logic [31:0] m_ce;
    logic        n_rd_en, n_flag, n_vld, n_busy, n_done;
    logic [2:0]  n_addr;
    logic [31:0] n_ce;
`ifdef BG_RD_CTRL_PERF_EN
    logic [15:0] m_stall, n_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] last_addr [2];

    always #5 clk = ~clk;

    bg_msm_rd_ctrl #(.ADDR_W(10), .RAM_LAT(1), .LEN_W(14)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_m), .flag_msm(flag_msm),
        .len(len), .issue_rdy(issue_rdy), .rd_en(m_rd_en), .rd_addr(m_addr),
        .ce_out(m_ce), .flag_msm_o(m_flag), .dout_vld(m_vld), .busy(m_busy),
        .done(m_done)
`ifdef BG_RD_CTRL_PERF_EN
        , .stall_cnt(m_stall)
`endif
    );

    bg_msm_rd_ctrl #(.ADDR_W(3), .RAM_LAT(3), .LEN_W(14)) u_dut_narrow (
        .clk(clk), .rst_n(rst_n), .start(start_n), .flag_msm(flag_msm),
        .len(len), .issue_rdy(issue_rdy), .rd_en(n_rd_en), .rd_addr(n_addr),
        .ce_out(n_ce), .flag_msm_o(n_flag), .dout_vld(n_vld), .busy(n_busy),
        .done(n_done)
`ifdef BG_RD_CTRL_PERF_EN
        , .stall_cnt(n_stall)
`endif
    );

    // Outputs of whichever instance the current scenario targets.
    logic        o_rd_en, o_flag, o_vld, o_busy, o_done;
    logic [9:0]  o_addr;
    logic [31:0] o_ce;
    always_comb begin
        o_rd_en = dut_sel ? n_rd_en : m_rd_en;
        o_addr  = dut_sel ? {7'd0, n_addr} : m_addr;
        o_ce    = dut_sel ? n_ce : m_ce;
        o_flag  = dut_sel ? n_flag : m_flag;
        o_vld   = dut_sel ? n_vld : m_vld;
        o_busy  = dut_sel ? n_busy : m_busy;
        o_done  = dut_sel ? n_done : m_done;
    end

    // One command, checked every cycle against a beat schedule.
    // mode: 0 = permit always, 1 = permit 1,0,1,0..., 2 = random permit.
    // restart: issue a second start (different len/mode) one cycle later.
    task automatic run_cmd(input bit sel, input bit msm, input int n,
                           input int mode, input bit restart);
        int          lat, aw, nb, last_k, done_k, stall_exp, vld_cnt, b;
        bit          rdy_a [512];
        int          beat_at [512];
        logic [9:0]  mask, ea;
        logic [31:0] ece;
        logic        erd, ev;

        lat  = sel ? 3 : 1;
        aw   = sel ? 3 : 10;
        mask = 10'((1 << aw) - 1);
        for (int i = 0; i < 512; i++) begin
            beat_at[i] = -1;
            rdy_a[i]   = (mode == 0) ? 1'b1 :
                         (mode == 1) ? ((i % 2) == 0) :
                         ($urandom_range(0, 3) != 0);
        end
        // Cycle j's permit issues beat nb, which is visible at sample j+1.
        nb = 0; last_k = 0; stall_exp = 0;
        for (int j = 0; nb < n && j < 500; j++) begin
            if (j >= 400) rdy_a[j] = 1'b1;
            if (rdy_a[j]) begin
                beat_at[j+1] = nb;
                nb++;
                last_k = j + 1;
            end else if (j >= 1) begin
                stall_exp++;
            end
        end
        done_k  = (n == 0) ? 1 : last_k + lat + 2;
        vld_cnt = 0;
        dut_sel = sel;

        for (int k = 0; k <= done_k + 1; k++) begin
            if (k >= 1) begin
                b   = beat_at[k];
                erd = (b >= 0);
                ece = 32'h0;
                ea  = last_addr[sel];
                if (erd) begin
                    if (msm) begin
                        ea = 10'(b / 8) & mask;
                        for (int q = 0; q < 4; q++) ece[q*8 + (b % 8)] = 1'b1;
                    end else begin
                        ea  = 10'(b) & mask;
                        ece = 32'hFFFF_FFFF;
                    end
                    last_addr[sel] = ea;
                end
                ev = (k - lat - 1 >= 1) && (beat_at[k-lat-1] >= 0);
                n_checks++;
                if ({o_rd_en, o_addr, o_ce} !== {erd, ea, ece}) begin
                    n_errors++;
                    $display("FAIL rd sel=%0d len=%0d cyc=%0d: got en=%b addr=%0d ce=%h, expected en=%b addr=%0d ce=%h",
                             sel, n, k, o_rd_en, o_addr, o_ce, erd, ea, ece);
                end
                n_checks++;
                if ({o_vld, o_busy, o_done, o_flag} !==
                    {ev, (k <= done_k), (k == done_k), msm}) begin
                    n_errors++;
                    $display("FAIL ctl sel=%0d len=%0d cyc=%0d: got vld/busy/done/flag=%b%b%b%b, expected %b%b%b%b",
                             sel, n, k, o_vld, o_busy, o_done, o_flag,
                             ev, (k <= done_k), (k == done_k), msm);
                end
                if (o_vld === 1'b1) vld_cnt++;
            end
            if (k == done_k + 1) break;
            start     = (k == 0) || (restart && k == 1);
            len       = (k == 0) ? 14'(n) : 14'd5;
            flag_msm  = (k == 0) ? msm : ~msm;
            issue_rdy = rdy_a[k];
            @(negedge clk);
        end
        start = 1'b0;

        n_checks++;
        if (vld_cnt != n) begin
            n_errors++;
            $display("FAIL vld_count sel=%0d: got %0d, expected %0d", sel, vld_cnt, n);
        end
`ifdef BG_RD_CTRL_PERF_EN
        n_checks++;
        if ((sel ? n_stall : m_stall) !== 16'(stall_exp)) begin
            n_errors++;
            $display("FAIL stall_cnt sel=%0d: got %0d, expected %0d",
                     sel, (sel ? n_stall : m_stall), stall_exp);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flag_msm = 1'b0; len = '0;
        issue_rdy = 1'b0; dut_sel = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_rd_en, m_addr, m_ce, m_flag, m_vld, m_busy, m_done} !== '0) begin
            n_errors++;
            $display("FAIL reset_main: got en=%b addr=%0d ce=%h flag=%b vld=%b busy=%b done=%b, expected all 0",
                     m_rd_en, m_addr, m_ce, m_flag, m_vld, m_busy, m_done);
        end
        n_checks++;
        if ({n_rd_en, n_addr, n_ce, n_flag, n_vld, n_busy, n_done} !== '0) begin
            n_errors++;
            $display("FAIL reset_narrow: got en=%b addr=%0d ce=%h flag=%b vld=%b busy=%b done=%b, expected all 0",
                     n_rd_en, n_addr, n_ce, n_flag, n_vld, n_busy, n_done);
        end
        rst_n = 1'b1;
        issue_rdy = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_rd_en, m_busy, m_done, m_vld} !== 4'b0) begin
            n_errors++;
            $display("FAIL idle_no_start: got en/busy/done/vld=%b%b%b%b, expected 0000",
                     m_rd_en, m_busy, m_done, m_vld);
        end
        last_addr[0] = '0;
        last_addr[1] = '0;
    endtask

    task automatic test_ntt_basic();
        run_cmd(1'b0, 1'b0, 4, 0, 1'b0);
    endtask

    task automatic test_msm_sequence();
        run_cmd(1'b0, 1'b1, 10, 0, 1'b0);
    endtask

    task automatic test_msm_stall();
        run_cmd(1'b0, 1'b1, 6, 1, 1'b0);
    endtask

    task automatic test_len_zero();
        run_cmd(1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_cmd(1'b0, 1'b0, 3, 0, 1'b0);
        run_cmd(1'b0, 1'b1, 5, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            run_cmd(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 20)), 2, 1'b0);
        end
    endtask

    task automatic test_addr_wrap();
        run_cmd(1'b1, 1'b0, 10, 0, 1'b0);
        run_cmd(1'b1, 1'b1, 20, 2, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        dut_sel = 1'b0;
        start = 1'b1; len = 14'd4; flag_msm = 1'b0; issue_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        // Last beat on the strobe; two beats still behind the output stage.
        n_checks++;
        if ({m_rd_en, m_addr} !== {1'b1, 10'd3}) begin
            n_errors++;
            $display("FAIL drain_precond: got en=%b addr=%0d, expected en=1 addr=3", m_rd_en, m_addr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_rd_en, m_addr, m_ce, m_flag, m_vld, m_busy, m_done} !== '0) begin
            n_errors++;
            $display("FAIL reset_in_drain: got en=%b addr=%0d ce=%h flag=%b vld=%b busy=%b done=%b, expected all 0",
                     m_rd_en, m_addr, m_ce, m_flag, m_vld, m_busy, m_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({m_rd_en, m_vld, m_busy, m_done} !== 4'b0) begin
                n_errors++;
                $display("FAIL post_reset cyc=%0d: got en/vld/busy/done=%b%b%b%b, expected 0000",
                         k, m_rd_en, m_vld, m_busy, m_done);
            end
        end
        last_addr[0] = '0;
        last_addr[1] = '0;
    endtask

    initial begin
        test_reset();
        test_ntt_basic();
        test_msm_sequence();
        test_msm_stall();
        test_len_zero();
        test_back_to_back();
        test_random();
        test_addr_wrap();
        test_reset_mid_drain();
        test_ntt_basic();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
